// File: rtl/puzzle_ctrl.sv
// puzzle_ctrl -- game controller for the 2x2 sliding-tile picture puzzle.
//
// Owns the tile arrangement shown by the VGA renderer. It shuffles the tiles
// from a free-running LFSR, applies player moves, detects the solved
// arrangement (then reveals the missing quarter) and counts effective moves.
//
// Ports:
//   clk          system clock (shared with the renderer)
//   rst          asynchronous reset, active low
//   btn_shuffle  one-cycle pulse: start a new game
//   btn_up/down/left/right  one-cycle move pulses
//   img_nums     tile map {a,b,c,d}, 3 bits each; 0..3 image quarter, 4 blank
//   solved       high while in SOLVED
//   busy         high while shuffling
//   move_cnt     effective moves since last shuffle, saturating at 1023
module puzzle_ctrl #(
  parameter int unsigned SHUFFLE_MOVES = 32,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_shuffle,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [11:0] img_nums,
  output logic        solved,
  output logic        busy,
  output logic [9:0]  move_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHUFFLE = 2'd1,
    ST_PLAY    = 2'd2,
    ST_SOLVED  = 2'd3
  } state_t;

  // Full picture (d shows quarter 3) and the solved play layout (d blank).
  localparam logic [11:0] FULL_PIC    = 12'b000_001_010_011;
  localparam logic [11:0] PLAY_SOLVED = 12'b000_001_010_100;
  localparam logic [7:0]  SHUF_N      = 8'(SHUFFLE_MOVES);
  localparam logic [9:0]  CNT_MAX     = 10'h3FF;

  state_t      state_q;
  logic [15:0] lfsr_q;
  logic [11:0] img_q;
  logic [1:0]  bpos_q;      // blank position: a=0, b=1, c=2, d=3
  logic [7:0]  step_q;
  logic        solved_q;
  logic        busy_q;
  logic [9:0]  cnt_q;

  // Exchange the fields at positions p and q (position 0 is the MSB field).
  function automatic logic [11:0] swap_fields(input logic [11:0] img,
                                              input logic [1:0]  p,
                                              input logic [1:0]  q);
    logic [11:0] r;
    int unsigned lo_p;
    int unsigned lo_q;
    lo_p = 9 - 3 * int'(p);
    lo_q = 9 - 3 * int'(q);
    r = img;
    r[lo_p +: 3] = img[lo_q +: 3];
    r[lo_q +: 3] = img[lo_p +: 3];
    return r;
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
  logic lfsr_fb;
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= LFSR_SEED;
    else      lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
  end

  // Shuffle swap: flipping bit 1 of bpos crosses rows (vertical), flipping
  // bit 0 crosses columns (horizontal), so every bpos has one of each.
  logic [1:0]  shuf_partner_d;
  logic [11:0] shuf_img_d;
  assign shuf_partner_d = lfsr_q[0] ? (bpos_q ^ 2'b10) : (bpos_q ^ 2'b01);
  assign shuf_img_d     = swap_fields(img_q, bpos_q, shuf_partner_d);

  // Move decode with fixed priority up > down > left > right. The highest
  // pressed direction is the one action taken, even if it turns out a no-op.
  logic        mv_ok_d;
  logic [1:0]  mv_partner_d;
  logic [11:0] mv_img_d;

  always_comb begin
    mv_ok_d      = 1'b0;
    mv_partner_d = bpos_q;
    if (btn_up) begin
      mv_ok_d      = ~bpos_q[1];
      mv_partner_d = bpos_q ^ 2'b10;
    end else if (btn_down) begin
      mv_ok_d      = bpos_q[1];
      mv_partner_d = bpos_q ^ 2'b10;
    end else if (btn_left) begin
      mv_ok_d      = ~bpos_q[0];
      mv_partner_d = bpos_q ^ 2'b01;
    end else if (btn_right) begin
      mv_ok_d      = bpos_q[0];
      mv_partner_d = bpos_q ^ 2'b01;
    end
  end

  assign mv_img_d = swap_fields(img_q, bpos_q, mv_partner_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      img_q    <= FULL_PIC;
      bpos_q   <= 2'd3;
      step_q   <= 8'd0;
      solved_q <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= 10'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_SOLVED: begin
          if (btn_shuffle) begin
            state_q  <= ST_SHUFFLE;
            img_q    <= PLAY_SOLVED;
            bpos_q   <= 2'd3;
            step_q   <= 8'd0;
            cnt_q    <= 10'd0;
            busy_q   <= 1'b1;
            solved_q <= 1'b0;
          end
        end

        ST_SHUFFLE: begin
          if (step_q != SHUF_N) begin
            img_q  <= shuf_img_d;
            bpos_q <= shuf_partner_d;
            step_q <= step_q + 8'd1;
          end else if (img_q == PLAY_SOLVED) begin
            // A shuffle that lands back on the solution is not a game.
            img_q  <= shuf_img_d;
            bpos_q <= shuf_partner_d;
          end else begin
            state_q <= ST_PLAY;
            busy_q  <= 1'b0;
          end
        end

        ST_PLAY: begin
          if (btn_shuffle) begin
            state_q  <= ST_SHUFFLE;
            img_q    <= PLAY_SOLVED;
            bpos_q   <= 2'd3;
            step_q   <= 8'd0;
            cnt_q    <= 10'd0;
            busy_q   <= 1'b1;
            solved_q <= 1'b0;
          end else if (img_q == PLAY_SOLVED) begin
            // Solved layout was shown for one cycle; now reveal quarter 3.
            state_q     <= ST_SOLVED;
            solved_q    <= 1'b1;
            img_q[2:0]  <= 3'd3;
          end else if (mv_ok_d) begin
            img_q  <= mv_img_d;
            bpos_q <= mv_partner_d;
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 10'd1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign img_nums = img_q;
  assign solved   = solved_q;
  assign busy     = busy_q;
  assign move_cnt = cnt_q;

endmodule
